// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between instruction fetch and data access.
// Define MEM_ARB_STARVATION_GUARD_EN to let a starved fetch override data priority.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;
endpackage

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_w_data,
    input  write_width_t    d_w_width,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    output write_width_t    mem_w_width,
    output logic            mem_w_enable,
    input  logic [XLEN-1:0] mem_r_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t owner_q, owner_d;
    logic   fetch_first;

`ifdef MEM_ARB_STARVATION_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    always_ff @(posedge clock) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt)
            starve_d = '0;
        else if (if_req && starve_q != LIMIT)
            starve_d = starve_q + CW'(1);
    end

    assign fetch_first = (starve_q == LIMIT);
`else
    assign fetch_first = 1'b0;
`endif

    // Only one grant per cycle, so the shared port never sees a collision.
    always_comb begin
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        owner_d = OWN_NONE;
        if (!reset) begin
            if (if_req && (!d_req || fetch_first))
                if_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
        end
        if (if_gnt)
            owner_d = OWN_IF;
        else if (d_gnt && !d_we)
            owner_d = OWN_D;
    end

    always_ff @(posedge clock) begin
        if (reset) owner_q <= OWN_NONE;
        else       owner_q <= owner_d;
    end

    assign mem_addr     = d_gnt ? d_addr : if_addr;
    assign mem_w_data   = d_w_data;
    assign mem_w_width  = d_w_width;
    assign mem_w_enable = d_gnt & d_we;

    assign if_rvalid = !reset && (owner_q == OWN_IF);
    assign d_rvalid  = !reset && (owner_q == OWN_D);
    assign if_rdata  = mem_r_data;
    assign d_rdata   = mem_r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corners,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         if_req, if_gnt, if_rvalid;
    logic [31:0]  if_addr, if_rdata;
    logic         d_req, d_we, d_gnt, d_rvalid;
    logic [31:0]  d_addr, d_w_data, d_rdata;
    write_width_t d_w_width, mem_w_width;
    logic [31:0]  mem_addr, mem_w_data, mem_r_data;
    logic         mem_w_enable;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_w_data(d_w_data), .d_w_width(d_w_width),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_w_width(mem_w_width), .mem_w_enable(mem_w_enable),
        .mem_r_data(mem_r_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wkey(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input write_width_t w);
        logic [31:0] r;
        r = old;
        case (w)
            write_byte: r[7:0]  = wd[7:0];
            write_half: r[15:0] = wd[15:0];
            default:    r       = wd;
        endcase
        return r;
    endfunction

    // Memory environment: synchronous read, write on strobe.
    logic [31:0] env_mem [logic [31:0]];
    always @(posedge clock) begin
        logic [31:0] k, old;
        k   = wkey(mem_addr);
        old = env_mem.exists(k) ? env_mem[k] : dflt(k);
        mem_r_data <= old;
        if (mem_w_enable) env_mem[k] = merge(old, mem_w_data, mem_w_width);
    end

    // Reference model: expected contents plus one outstanding read per port.
    logic [31:0] ref_mem [logic [31:0]];
    int          m_starve = 0;
    logic        m_irv = 1'b0, m_drv = 1'b0;
    logic [31:0] m_idata, m_ddata;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = wkey(a);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
    endfunction

    always @(negedge clock) begin
        logic e_ig, e_dg, e_we;
        if (reset) begin
            e_ig = 1'b0;
            e_dg = 1'b0;
        end else begin
            e_ig = if_req && (!d_req || (GUARD && m_starve >= STARVE_LIMIT));
            e_dg = d_req && !e_ig;
        end
        e_we = e_dg && d_we;
        chk1("m_if_gnt", if_gnt, e_ig);
        chk1("m_d_gnt", d_gnt, e_dg);
        chk1("m_w_enable", mem_w_enable, e_we);
        chk1("m_if_rvalid", if_rvalid, m_irv && !reset);
        chk1("m_d_rvalid", d_rvalid, m_drv && !reset);
        if (m_irv && !reset) chk("m_if_rdata", if_rdata, m_idata);
        if (m_drv && !reset) chk("m_d_rdata", d_rdata, m_ddata);
        if (e_ig || e_dg) chk("m_mem_addr", mem_addr, e_dg ? d_addr : if_addr);
        if (e_we) begin
            chk("m_w_data", mem_w_data, d_w_data);
            chk("m_w_width", 32'(mem_w_width), 32'(d_w_width));
        end
        if (reset) begin
            m_starve = 0;
            m_irv    = 1'b0;
            m_drv    = 1'b0;
        end else begin
            if (e_ig) m_starve = 0;
            else if (if_req && m_starve < STARVE_LIMIT) m_starve++;
            m_irv   = e_ig;
            m_idata = ref_rd(if_addr);
            m_drv   = e_dg && !d_we;
            m_ddata = ref_rd(d_addr);
            if (e_we) ref_mem[wkey(d_addr)] = merge(ref_rd(d_addr), d_w_data, d_w_width);
        end
    end

    typedef struct packed {
        logic [3:0] in;   // reset, if_req, d_req, d_we
        logic [4:0] exp;  // if_gnt, d_gnt, w_enable, if_rvalid, d_rvalid
    } vec_t;
    vec_t tbl [11];

    task automatic starve_seq(input string nm);
        int   first;
        logic dg_after;
        first    = -1;
        dg_after = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0001_0000;
        d_req    = 1'b1;
        d_we     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            d_addr = 32'h0002_0000 + 32'(4 * i);
            @(negedge clock);
            if (first >= 0 && i == first + 1) dg_after = d_gnt;
            if (if_gnt && first < 0) first = i;
            @(posedge clock); #1;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
`ifdef MEM_ARB_STARVATION_GUARD_EN
        chk({nm, "_first_if_gnt"}, first, 4);
        chk1({nm, "_data_wins_again"}, dg_after, 1'b1);
`else
        chk({nm, "_first_if_gnt"}, first, -1);
`endif
    endtask

    initial begin
        logic ig, dg;
        tbl[0]  = {4'b0000, 5'b00000};
        tbl[1]  = {4'b0100, 5'b10000};
        tbl[2]  = {4'b0010, 5'b01010};
        tbl[3]  = {4'b0110, 5'b01001};
        tbl[4]  = {4'b0111, 5'b01101};
        tbl[5]  = {4'b0100, 5'b10000};
        tbl[6]  = {4'b0000, 5'b00010};
        tbl[7]  = {4'b0110, 5'b01000};
        tbl[8]  = {4'b1110, 5'b00000};
        tbl[9]  = {4'b0100, 5'b10000};
        tbl[10] = {4'b0000, 5'b00010};

        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0001_0000; d_addr = 32'h0002_0010;
        d_w_data = 32'h1234_5678; d_w_width = write_word;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) begin
            {reset, if_req, d_req, d_we} = tbl[i].in;
            @(negedge clock);
            chk($sformatf("vec%0d", i),
                {27'b0, if_gnt, d_gnt, mem_w_enable, if_rvalid, d_rvalid},
                {27'b0, tbl[i].exp});
            @(posedge clock); #1;
        end

        // Idle fetch
        if_req = 1'b1; if_addr = 32'h0001_0000; d_req = 1'b0;
        @(negedge clock); chk1("idle_if_gnt", if_gnt, 1'b1);
        @(posedge clock); #1; if_req = 1'b0;
        @(negedge clock);
        chk1("idle_if_rvalid", if_rvalid, 1'b1);
        chk("idle_if_rdata", if_rdata, dflt(32'h0001_0000));
        @(posedge clock); #1;

        // Store then load back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0002_0004;
        d_w_data = 32'hDEAD_BEEF; d_w_width = write_word;
        @(negedge clock);
        chk1("store_wen", mem_w_enable, 1'b1);
        chk1("store_d_gnt", d_gnt, 1'b1);
        @(posedge clock); #1; d_we = 1'b0;
        @(negedge clock);
        chk1("store_no_rvalid", d_rvalid, 1'b0);
        chk1("load_d_gnt", d_gnt, 1'b1);
        @(posedge clock); #1; d_req = 1'b0;
        @(negedge clock);
        chk1("load_rvalid", d_rvalid, 1'b1);
        chk("load_rdata", d_rdata, 32'hDEAD_BEEF);
        @(posedge clock); #1;

        // Conflict: data first, fetch when data drops
        if_req = 1'b1; if_addr = 32'h0001_0000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0002_0010;
        @(negedge clock);
        chk1("conf_d_gnt", d_gnt, 1'b1);
        chk1("conf_if_gnt", if_gnt, 1'b0);
        @(posedge clock); #1; d_req = 1'b0;
        @(negedge clock);
        chk1("conf_d_rvalid", d_rvalid, 1'b1);
        chk("conf_d_rdata", d_rdata, 32'h1234_5678);
        chk1("conf_if_gnt_after", if_gnt, 1'b1);
        @(posedge clock); #1; if_req = 1'b0;

        starve_seq("starve");

        // Reset while a fetch is requested
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h0001_0000; d_req = 1'b0;
        @(negedge clock); chk1("rst_if_gnt", if_gnt, 1'b0);
        @(posedge clock); #1; reset = 1'b0; if_req = 1'b0;
        @(negedge clock); chk1("rst_no_rvalid", if_rvalid, 1'b0);
        @(posedge clock); #1;
        starve_seq("post_reset");

        // Pipelined fetch then load
        if_req = 1'b1; if_addr = 32'h0001_0004;
        @(negedge clock); chk1("pipe_if_gnt", if_gnt, 1'b1);
        @(posedge clock); #1;
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0002_0008;
        @(negedge clock);
        chk1("pipe_d_gnt", d_gnt, 1'b1);
        chk1("pipe_if_rvalid", if_rvalid, 1'b1);
        chk1("pipe_d_rvalid_early", d_rvalid, 1'b0);
        @(posedge clock); #1; d_req = 1'b0;
        @(negedge clock);
        chk1("pipe_d_rvalid", d_rvalid, 1'b1);
        chk1("pipe_if_rvalid_late", if_rvalid, 1'b0);
        @(posedge clock); #1;

        // Random traffic; requests held until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            ig = if_gnt;
            dg = d_gnt;
            @(posedge clock); #1;
            reset = ($urandom_range(0, 63) == 0);
            if (!if_req || ig) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 32'h0002_0000 + 32'(4 * $urandom_range(0, 15));
            end
            if (!d_req || dg) begin
                d_req     = ($urandom_range(0, 3) != 0);
                d_we      = $urandom_range(0, 1) == 1;
                d_addr    = 32'h0002_0000 + 32'(4 * $urandom_range(0, 15));
                d_w_data  = $urandom;
                d_w_width = write_width_t'($urandom_range(0, 2));
            end
        end
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
